// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: MSB-first bits on en strobes, one word presented per NB_REG bits.
// Define SHIFT_DESERIALIZER_OVERRUN_EN to drop words on overrun and raise a sticky o_overrun.
module shift_deserializer #(
  parameter int NB_REG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              i_data,
  input  logic              i_ready,
  output logic [NB_REG-1:0] o_value,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int CW = (NB_REG > 2) ? $clog2(NB_REG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB_REG - 1);

  typedef enum logic {IDLE = 1'b0, RX = 1'b1} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  // Only NB_REG-1 history bits are needed; the final bit comes straight from i_data.
  logic [NB_REG-2:0]   shift;
  logic [NB_REG-1:0]   word;

  assign word = {shift, i_data};

`ifndef SHIFT_DESERIALIZER_OVERRUN_EN
  assign o_overrun = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      o_value <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
      o_overrun <= 1'b0;
`endif
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= RX;
            o_busy <= 1'b1;
            cnt    <= '0;
            shift  <= '0;
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
            o_overrun <= 1'b0;
`endif
          end
        end
        RX: begin
          if (start) begin
            cnt   <= '0;
            shift <= '0;
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
            o_overrun <= 1'b0;
`endif
          end else if (en) begin
            shift <= word[NB_REG-2:0];
            if (cnt == LAST) begin
              cnt <= '0;
              // A consumer taking the old word this cycle frees the slot for the new one.
              if (!o_valid || i_ready) begin
                o_value <= word;
                o_valid <= 1'b1;
              end else begin
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
                o_overrun <= 1'b1;
`else
                o_value <= word;
                o_valid <= 1'b1;
`endif
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer (NB_REG=8) against a queue-based model.
module tb_shift_deserializer;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic          i_data = 1'b0;
  logic          i_ready = 1'b0;
  logic [NB-1:0] o_value;
  logic          o_valid;
  logic          o_busy;
  logic          o_overrun;

  int total = 0;
  int bad = 0;

  // Reference model state: received bits since arming, plus the output slot.
  bit            m_armed;
  int            m_bits[$];
  logic [NB-1:0] m_value;
  bit            m_valid;
  bit            m_ovr;

  shift_deserializer #(.NB_REG(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .i_data   (i_data),
    .i_ready  (i_ready),
    .o_value  (o_value),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0;
    m_bits.delete();
    m_value = '0;
    m_valid = 0;
    m_ovr   = 0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit d, input bit r);
    bit consume;
    bit done;
    int w;
    consume = m_valid && r;
    done = 0;
    w = 0;
    if (s) begin
      m_armed = 1;
      m_bits.delete();
      m_ovr = 0;
    end else if (m_armed && e) begin
      m_bits.push_back(int'(d));
      if (m_bits.size() == NB) begin
        for (int i = 0; i < NB; i++) w = w * 2 + m_bits[i];
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_value = w[NB-1:0];
        m_valid = 1;
      end else begin
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
        m_ovr = 1;
`else
        m_value = w[NB-1:0];
`endif
      end
    end else if (consume) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".value"}, 32'(o_value), 32'(m_value));
    chk({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
    chk({tag, ".busy"}, 32'(o_busy), 32'(m_armed));
    chk({tag, ".ovr"}, 32'(o_overrun), 32'(m_ovr));
  endtask

  // Called at posedge+1; applies inputs, clocks once, checks at the next posedge+1.
  task automatic cycle(input string tag, input bit s, input bit e, input bit d, input bit r);
    start = s; en = e; i_data = d; i_ready = r;
    @(posedge clk);
    model_step(s, e, d, r);
    #1;
    compare_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [NB-1:0] w, input bit r_body, input bit r_last);
    for (int i = NB - 1; i >= 0; i--)
      cycle(tag, 1'b0, 1'b1, w[i], (i == 0) ? r_last : r_body);
  endtask

  task automatic drain();
    cycle("drain", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #1;
    chk("por.value", 32'(o_value), 32'h0);
    chk("por.valid", 32'(o_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Strobes before any start are ignored.
    for (int i = 0; i < 10; i++) cycle("idle_en", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_en.valid", 32'(o_valid), 32'h0);

    // Single word 0xB2, then one-cycle consume.
    cycle("start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word("single", 8'hB2, 1'b0, 1'b0);
    chk("single.value", 32'(o_value), 32'hB2);
    chk("single.valid", 32'(o_valid), 32'h1);
    cycle("consume", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("consume.valid", 32'(o_valid), 32'h0);

    // Back-to-back with i_ready held high.
    send_word("b2b0", 8'hB2, 1'b1, 1'b1);
    chk("b2b0.value", 32'(o_value), 32'hB2);
    chk("b2b0.valid", 32'(o_valid), 32'h1);
    send_word("b2b1", 8'h5A, 1'b1, 1'b1);
    chk("b2b1.value", 32'(o_value), 32'h5A);
    chk("b2b1.valid", 32'(o_valid), 32'h1);
    chk("b2b1.ovr", 32'(o_overrun), 32'h0);

    // Overrun.
    drain();
    cycle("start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_word("ovr0", 8'hB2, 1'b0, 1'b0);
    send_word("ovr1", 8'h0F, 1'b0, 1'b0);
    chk("ovr.valid", 32'(o_valid), 32'h1);
`ifdef SHIFT_DESERIALIZER_OVERRUN_EN
    chk("ovr.value", 32'(o_value), 32'hB2);
    chk("ovr.flag", 32'(o_overrun), 32'h1);
`else
    chk("ovr.value", 32'(o_value), 32'h0F);
    chk("ovr.flag", 32'(o_overrun), 32'h0);
`endif

    // Restart with colliding strobe.
    drain();
    cycle("start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("partial", 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("restart", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("restart.ovr", 32'(o_overrun), 32'h0);
    send_word("restart", 8'hC3, 1'b0, 1'b0);
    chk("restart.value", 32'(o_value), 32'hC3);
    chk("restart.valid", 32'(o_valid), 32'h1);

    // Completion in the same cycle as consume.
    drain();
    send_word("simul0", 8'hB2, 1'b0, 1'b0);
    send_word("simul1", 8'h5A, 1'b0, 1'b1);
    chk("simul.value", 32'(o_value), 32'h5A);
    chk("simul.valid", 32'(o_valid), 32'h1);
    chk("simul.ovr", 32'(o_overrun), 32'h0);

    // Async reset mid-word, mid-cycle.
    send_word("pre_rst", 8'hFF, 1'b0, 1'b0);
    cycle("pre_rst", 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.value", 32'(o_value), 32'h0);
    chk("arst.valid", 32'(o_valid), 32'h0);
    chk("arst.busy", 32'(o_busy), 32'h0);
    chk("arst.ovr", 32'(o_overrun), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cycle("post_rst", 1'b0, 1'b1, 1'(i), 1'b0);
    chk("post_rst.valid", 32'(o_valid), 32'h0);
    chk("post_rst.busy", 32'(o_busy), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
            1'($urandom), ($urandom_range(0, 9) < 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter NB_REG, default 32, meaning word width in bits (legal range NB_REG >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1  frame start; discards any partial word and arms reception.
REQ-005 SHALL have port en  input  1  bit strobe; i_data is sampled on clk edges where en=1.
REQ-006 SHALL have port i_data  input  1  serial data, MSB first.
REQ-007 SHALL have port i_ready  input  1  consumer accepts o_value when o_valid=1.
REQ-008 SHALL have port o_value  output  NB_REG  last completed word.
REQ-009 SHALL have port o_valid  output  1  o_value holds an unconsumed word.
REQ-010 SHALL have port o_busy  output  1  high in state RX.
REQ-011 SHALL have port o_overrun  output  1  sticky overrun flag (see Configuration).

Function
REQ-012 SHALL implement two states: IDLE and RX; o_busy=1 exactly in RX.
REQ-013 In IDLE, en and i_data SHALL be ignored; start SHALL move the block to RX with the bit counter at 0 and the shift register cleared.
REQ-014 In RX, start SHALL clear the counter and shift register, stay in RX and leave o_value/o_valid unchanged; start has priority over en in the same cycle (that bit is discarded).
REQ-015 In RX with en=1, the shift register SHALL shift left by one with i_data entering the LSB, and the counter SHALL increment.
REQ-016 On the strobe capturing bit NB_REG-1, the completed word {shift[NB_REG-2:0], i_data} SHALL be presented on o_value with o_valid=1 at the next clk edge (1-cycle latency after the last strobe).
REQ-017 On word completion, the counter SHALL wrap to 0 and the block SHALL stay in RX, so back-to-back words need no new start.
REQ-018 o_valid SHALL clear on the edge where o_valid=1 and i_ready=1, unless a new word completes in that same cycle.
REQ-019 When a word completes while o_valid=1 and i_ready=1, the old word SHALL be consumed, the new word loaded, o_valid stays 1, and no overrun SHALL be flagged.
REQ-020 When a word completes while o_valid=1 and i_ready=0, an overrun occurs; handling is per REQ-024/REQ-025.
REQ-021 i_ready with o_valid=0 SHALL have no effect.

Reset
REQ-022 While rst=1, state SHALL be IDLE; counter, shift register and o_value SHALL be 0; o_valid, o_busy and o_overrun SHALL be 0, independent of clk.
REQ-023 Reset asserted mid-word SHALL discard the partial word; after release, en SHALL be ignored until start.

Configuration
REQ-024 With macro SHIFT_DESERIALIZER_OVERRUN_EN defined, on overrun the new word SHALL be dropped, o_value and o_valid kept, and o_overrun set to 1; o_overrun SHALL clear only on rst or start.
REQ-025 Without SHIFT_DESERIALIZER_OVERRUN_EN, on overrun the new word SHALL overwrite o_value, o_valid stays 1, and o_overrun SHALL be constant 0.

Verification (NB_REG=8)
REQ-026 Reset: assert rst asynchronously mid-cycle -> o_value=0x00, o_valid=0, o_busy=0, o_overrun=0 immediately; en strobes after release give no o_valid.
REQ-027 Single word: start, then 8 strobes with bits 1,0,1,1,0,0,1,0 -> o_valid=1, o_value=0xB2 one cycle after the 8th strobe; i_ready=1 for one cycle -> o_valid=0 next edge.
REQ-028 Back-to-back: i_ready held 1, 16 consecutive strobes carrying 0xB2 then 0x5A -> two o_valid pulses with 0xB2 then 0x5A, o_overrun=0.
REQ-029 Overrun: i_ready=0, words 0xB2 then 0x0F -> with macro o_value=0xB2 and o_overrun=1; without macro o_value=0x0F and o_overrun=0.
REQ-030 Restart: start, 3 strobes of 1s, start again plus an en on that same cycle, then 8 strobes with 0xC3 -> o_value=0xC3; the 3 earlier bits and the colliding strobe are absent.
REQ-031 Simultaneous: o_valid=1 with 0xB2, completion of 0x5A in the same cycle as i_ready=1 -> o_value=0x5A, o_valid stays 1, o_overrun=0.
